neuron_accumulate: RTL and testbench

//  Serial multiply-accumulate neuron stage directly upstream of sigmoid. Accepts a vector of N

---
 rtl/neuron_accumulate.sv | 131 +++++++++++++
 tb/tb_neuron_accumulate.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulate.sv
// Serial multiply-accumulate neuron feeding a sigmoid stage; forms bias + sum(w_i*x_i)
// in Q8.8 and, when training, folds the returned delta back into its weights and bias.
module neuron_accumulate #(
    parameter int N          = 2,
    parameter int RATE_SHIFT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            train,
    input  logic            input_valid,
    input  logic [N*8-1:0]  input_data,
    output logic            input_ready,
    output logic            argument_valid,
    output logic [15:0]     argument_data,
    input  logic            argument_ready,
    input  logic            delta_valid,
    input  logic [15:0]     delta_data,
    output logic            delta_ready
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, MAC, ARG, DELTA, UPDATE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [31:0]       acc_q, acc_d;
    logic signed [15:0]       w_q [N];
    logic signed [15:0]       bias_q;
    logic signed [15:0]       arg_q;
    logic signed [15:0]       delta_q;
    logic [7:0]               x_q [N];

    logic                     last;
    logic signed [15:0]       w_sel;
    logic signed [8:0]        x_sel;
    logic signed [24:0]       mac_term;
    logic signed [24:0]       upd_prod;
    logic signed [24:0]       upd_term;
    logic signed [15:0]       bias_step;
    logic signed [15:0]       w_upd;
    logic signed [15:0]       bias_upd;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7FFF;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    assign last      = (idx_q == IDX_W'(N - 1));
    assign w_sel     = w_q[idx_q];
    assign x_sel     = $signed({1'b0, x_q[idx_q]});
    assign mac_term  = 25'(w_sel) * 25'(x_sel);
    // Update step: delta*x is Q8.8*Q0.8 = Q.16, so >>>8 returns to Q8.8 before the rate shift.
    assign upd_prod  = 25'(delta_q) * 25'(x_sel);
    assign upd_term  = upd_prod >>> (8 + RATE_SHIFT);
    assign bias_step = delta_q >>> RATE_SHIFT;
    assign w_upd     = sat16(32'(w_sel) + 32'(upd_term));
    assign bias_upd  = sat16(32'(bias_q) + 32'(bias_step));

    assign input_ready    = (state_q == IDLE);
    assign argument_valid = (state_q == ARG);
    assign delta_ready    = (state_q == DELTA);
    assign argument_data  = arg_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (input_valid) begin
                    state_d = MAC;
                    idx_d   = '0;
                    acc_d   = 32'(bias_q) <<< 8;
                end
            end
            MAC: begin
                acc_d = acc_q + 32'(mac_term);
                if (last) state_d = ARG;
                else      idx_d   = idx_q + IDX_W'(1);
            end
            ARG: begin
                if (argument_ready) state_d = train ? DELTA : IDLE;
            end
            DELTA: begin
                if (delta_valid) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (last) state_d = IDLE;
                else      idx_d   = idx_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            arg_q   <= '0;
            bias_q  <= '0;
            for (int i = 0; i < N; i++) w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            if (state_q == MAC && last) arg_q <= sat16(acc_d >>> 8);
            if (state_q == UPDATE) begin
                w_q[idx_q] <= w_upd;
                if (last) bias_q <= bias_upd;
            end
        end
    end

    // Operand latches: only meaningful after the handshake that loads them.
    always_ff @(posedge clock) begin
        if (state_q == IDLE && input_valid) begin
            for (int i = 0; i < N; i++) x_q[i] <= input_data[8*i +: 8];
        end
        if (state_q == DELTA && delta_valid) delta_q <= delta_data;
    end

endmodule

// File: tb/tb_neuron_accumulate.sv
// Scoreboard bench for neuron_accumulate: two instances (RATE_SHIFT 0 and 4) driven by
// directed vectors; a negedge monitor checks every argument handshake against a queue.
module tb_neuron_accumulate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  train          = '0;
    logic [1:0]  input_valid    = '0;
    logic [1:0]  input_ready;
    logic [1:0]  argument_valid;
    logic [1:0]  argument_ready = '0;
    logic [1:0]  delta_valid    = '0;
    logic [1:0]  delta_ready;
    logic [15:0] input_data    [2];
    logic [15:0] argument_data [2];
    logic [15:0] delta_data    [2];

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        neuron_accumulate #(.N(2), .RATE_SHIFT(g == 0 ? 0 : 4)) u_dut (
            .clock          (clk),
            .reset          (rst),
            .train          (train[g]),
            .input_valid    (input_valid[g]),
            .input_data     (input_data[g]),
            .input_ready    (input_ready[g]),
            .argument_valid (argument_valid[g]),
            .argument_data  (argument_data[g]),
            .argument_ready (argument_ready[g]),
            .delta_valid    (delta_valid[g]),
            .delta_data     (delta_data[g]),
            .delta_ready    (delta_ready[g])
        );
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [15:0] e;
        bit has;
        for (int d = 0; d < 2; d++) begin
            if (!rst && argument_valid[d] && argument_ready[d]) begin
                has = 1'b0;
                e   = '0;
                if (d == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); has = 1'b1; end
                if (d == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); has = 1'b1; end
                if (!has) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_arg dut%0d: got %h, expected no output", d, argument_data[d]);
                end else begin
                    check($sformatf("arg_dut%0d", d), argument_data[d], e);
                end
            end
        end
    end

    task automatic push_exp(input int d, input logic [15:0] e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            check("rst_input_ready", 16'(input_ready[d]), 16'h1);
            check("rst_delta_ready", 16'(delta_ready[d]), 16'h0);
            check("rst_arg_valid", 16'(argument_valid[d]), 16'h0);
            check("rst_arg_data", argument_data[d], 16'h0000);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // train is driven to the opposite of the eventual choice here; only the ARG handshake value counts.
    task automatic send_input(input int d, input logic [15:0] x, input logic tr);
        input_data[d]  = x;
        train[d]       = ~tr;
        input_valid[d] = 1'b1;
        check("in_ready_idle", 16'(input_ready[d]), 16'h1);
        @(posedge clk); #1;
        input_valid[d] = 1'b0;
    endtask

    task automatic wait_arg(input int d);
        int n = 0;
        while (argument_valid[d] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("arg_latency_cycle", 16'(n + 1), 16'd3);
        check("in_ready_in_arg", 16'(input_ready[d]), 16'h0);
    endtask

    task automatic take_arg(input int d, input logic tr);
        train[d]          = tr;
        argument_ready[d] = 1'b1;
        @(posedge clk); #1;
        argument_ready[d] = 1'b0;
        check("arg_valid_drop", 16'(argument_valid[d]), 16'h0);
        check("delta_ready_after_arg", 16'(delta_ready[d]), 16'(tr));
        if (!tr) check("idle_after_arg", 16'(input_ready[d]), 16'h1);
    endtask

    task automatic send_delta(input int d, input logic [15:0] dl);
        delta_data[d]  = dl;
        delta_valid[d] = 1'b1;
        @(posedge clk); #1;
        delta_valid[d] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("idle_after_update", 16'(input_ready[d]), 16'h1);
    endtask

    task automatic infer(input int d, input logic [15:0] x, input logic tr,
                         input logic [15:0] e, input logic [15:0] dl);
        push_exp(d, e);
        send_input(d, x, tr);
        wait_arg(d);
        take_arg(d, tr);
        if (tr) send_delta(d, dl);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        input_data[0] = '0; input_data[1] = '0;
        delta_data[0] = '0; delta_data[1] = '0;
        #1;
        apply_reset();

        // Untrained neuron: x0=0.5, x1=0.25 with zero weights gives 0, weights stay 0.
        infer(0, 16'h4080, 1'b0, 16'h0000, 16'h0000);
        infer(0, 16'h4080, 1'b0, 16'h0000, 16'h0000);

        // RATE_SHIFT=0: delta 1.0 with x0=0.5 -> w0=0.5, bias=1.0; then 1.0+0.25 = 0x0140.
        infer(0, 16'h0080, 1'b1, 16'h0000, 16'h0100);
        infer(0, 16'h0080, 1'b0, 16'h0140, 16'h0000);

        // Stall in ARG for 5 cycles with a stray input pulse.
        push_exp(0, 16'h0140);
        send_input(0, 16'h0080, 1'b0);
        wait_arg(0);
        for (int k = 0; k < 5; k++) begin
            input_data[0]  = 16'h00FF;
            input_valid[0] = (k == 1);
            @(posedge clk); #1;
            check("stall_valid", 16'(argument_valid[0]), 16'h1);
            check("stall_data", argument_data[0], 16'h0140);
            check("stall_in_ready", 16'(input_ready[0]), 16'h0);
        end
        input_valid[0] = 1'b0;
        take_arg(0, 1'b0);
        infer(0, 16'h0080, 1'b0, 16'h0140, 16'h0000);

        // Saturation: two max deltas -> bias clamps at 0x7FFF, w0=0x7FFE, output clamps.
        apply_reset();
        infer(0, 16'h0080, 1'b1, 16'h0000, 16'h7FFF);
        infer(0, 16'h0080, 1'b1, 16'h7FFF, 16'h7FFF);
        infer(0, 16'h0080, 1'b0, 16'h7FFF, 16'h0000);
        infer(0, 16'h0000, 1'b0, 16'h7FFF, 16'h0000);

        // Reset during MAC cycle 1 aborts and clears the saturated weights.
        send_input(0, 16'h0080, 1'b0);
        rst = 1'b1;
        #1;
        check("mac_rst_arg_valid", 16'(argument_valid[0]), 16'h0);
        check("mac_rst_in_ready", 16'(input_ready[0]), 16'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        infer(0, 16'h0080, 1'b0, 16'h0000, 16'h0000);

        // Reset during UPDATE after w0 has been written: no partial update survives.
        infer(0, 16'h0080, 1'b1, 16'h0000, 16'h0100);
        push_exp(0, 16'h0140);
        send_input(0, 16'h0080, 1'b1);
        wait_arg(0);
        take_arg(0, 1'b1);
        delta_data[0]  = 16'h0100;
        delta_valid[0] = 1'b1;
        @(posedge clk); #1;
        delta_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("upd_rst_in_ready", 16'(input_ready[0]), 16'h1);
        check("upd_rst_delta_ready", 16'(delta_ready[0]), 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        infer(0, 16'h0080, 1'b0, 16'h0000, 16'h0000);
        infer(0, 16'h0000, 1'b0, 16'h0000, 16'h0000);

        // RATE_SHIFT=4, delta=-1.0, x0=0xFF: w0 and bias both step by floor(...) = -16.
        // Next inference: (-16<<8) + (-16*255) = -8176, >>>8 floors to -32 = 0xFFE0.
        infer(1, 16'h00FF, 1'b1, 16'h0000, 16'hFF00);
        infer(1, 16'h00FF, 1'b0, 16'hFFE0, 16'h0000);
        infer(1, 16'h0000, 1'b0, 16'hFFF0, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", 16'(exp_q0.size()), 16'h0);
        check("q1_drained", 16'(exp_q1.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
